// File: rtl/cdbus_uart_bridge_pkg.sv
// Shared definitions for the UART-to-CSR bridge: FSM state encodings,
// header field positions and the burst-length rule (count 0 = 256).
package cdbus_uart_bridge_pkg;

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_CNT     = 4'd1;
  localparam logic [3:0] ST_WDATA   = 4'd2;
  localparam logic [3:0] ST_WSTROBE = 4'd3;
  localparam logic [3:0] ST_RREQ    = 4'd4;
  localparam logic [3:0] ST_RWAIT   = 4'd5;
  localparam logic [3:0] ST_RSEND   = 4'd6;
  localparam logic [3:0] ST_ACK     = 4'd7;

  localparam int HDR_W       = 7;
  localparam int HDR_RSV_HI  = 6;
  localparam int HDR_RSV_LO  = 5;
  localparam int HDR_ADDR_HI = 4;

  // A header is accepted only when both reserved bits are zero.
  function automatic logic hdr_ok(input logic [7:0] hdr);
    return hdr[HDR_RSV_HI:HDR_RSV_LO] == 2'b00;
  endfunction

  // Count byte to number of accesses; 9 bits so that 0 can mean 256.
  function automatic logic [8:0] burst_len(input logic [7:0] count);
    return (count == 8'd0) ? 9'd256 : {1'b0, count};
  endfunction

endpackage

// File: rtl/cdbus_uart_bridge_uart_rx.sv
// 8N1 UART receiver.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   rx             asynchronous serial input, idle high
//   start_edge     one-cycle pulse when a start bit edge is detected
//   byte_valid     one-cycle pulse, byte_data holds a well-framed byte
//   byte_err       one-cycle pulse, stop bit sampled low (byte dropped)
//   byte_data      last good byte
// Receiver FSM is a single busy flag plus a bit index (bit 0 = start,
// 1..8 = data LSB first, 9 = stop).
module cdbus_uart_bridge_uart_rx #(
  parameter int DIV = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       start_edge,
  output logic       byte_valid,
  output logic       byte_err,
  output logic [7:0] byte_data
);

  localparam logic [15:0] HALF = 16'(DIV / 2 - 1);
  localparam logic [15:0] FULL = 16'(DIV - 1);

  logic        sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic        busy_q, busy_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d, data_q, data_d;
  logic        valid_q, valid_d, err_q, err_d;
  logic        start;

  always_comb begin
    sync1_d = rx;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    // Falling edge on the synchronised line while not receiving.
    start   = !busy_q && prev_q && !sync2_q;
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = HALF;
      bit_d  = 4'd0;
    end else if (busy_q) begin
      if (cnt_q == 16'd0) begin
        cnt_d = FULL;
        bit_d = bit_q + 4'd1;
        if (bit_q == 4'd0) begin
          // Line back high at mid start bit: glitch, not a start bit.
          if (sync2_q) busy_d = 1'b0;
        end else if (bit_q <= 4'd8) begin
          shift_d = {sync2_q, shift_q[7:1]};
        end else begin
          busy_d = 1'b0;
          if (sync2_q) begin
            valid_d = 1'b1;
            data_d  = shift_q;
          end else begin
            err_d = 1'b1;
          end
        end
      end else begin
        cnt_d = cnt_q - 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      busy_q  <= 1'b0;
      cnt_q   <= 16'd0;
      bit_q   <= 4'd0;
      shift_q <= 8'd0;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign start_edge = start;
  assign byte_valid = valid_q;
  assign byte_err   = err_q;
  assign byte_data  = data_q;

endmodule

// File: rtl/cdbus_uart_bridge.sv
// UART-to-CSR bridge. Decodes header/count/data frames received over
// 8N1 UART into single-cycle CSR read/write strobes and returns read
// data or a header echo (write acknowledge) over tx.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   rx / tx             UART lines, idle high
//   chip_select         high while a decoded frame is in progress
//   csr_address         address latched from the header
//   csr_read/csr_write  one-cycle strobes (never both)
//   csr_readdata        sampled the cycle after csr_read
//   csr_writedata       valid with csr_write
//   dbg_state           current FSM state
// Handshake: the CSR bus has no back-pressure; a strobe is a complete
// transfer in the cycle it is high, read data is taken one cycle later.
module cdbus_uart_bridge
  import cdbus_uart_bridge_pkg::*;
#(
  parameter int DIV          = 16,
  parameter int TIMEOUT_BITS = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic       tx,
  output logic       chip_select,
  output logic [4:0] csr_address,
  output logic       csr_read,
  input  logic [7:0] csr_readdata,
  output logic       csr_write,
  output logic [7:0] csr_writedata,
  output logic [3:0] dbg_state
);

  localparam logic [15:0] FULL     = 16'(DIV - 1);
  localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT_BITS * DIV);

  logic       rx_start, byte_valid, byte_err;
  logic [7:0] byte_data;

  cdbus_uart_bridge_uart_rx #(.DIV(DIV)) u_rx (
    .clk        (clk),
    .rst_n      (reset_n),
    .rx         (rx),
    .start_edge (rx_start),
    .byte_valid (byte_valid),
    .byte_err   (byte_err),
    .byte_data  (byte_data)
  );

  logic [3:0]  state_q, state_d;
  logic [4:0]  addr_q, addr_d;
  logic        w_q, w_d;
  logic [8:0]  rem_q, rem_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [31:0] to_cnt_q, to_cnt_d;
  logic        tx_q, tx_d, tx_busy_q, tx_busy_d;
  logic [8:0]  tx_sh_q, tx_sh_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]  tx_bits_q, tx_bits_d;
  logic        tx_start, tx_done, timed_out;
  logic [7:0]  tx_data;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    w_d       = w_q;
    rem_d     = rem_q;
    wdata_d   = wdata_q;
    tx_start  = 1'b0;
    tx_data   = 8'h00;
    tx_done   = tx_busy_q && (tx_cnt_q == 16'd0) && (tx_bits_q == 4'd0);
    // Cycles since the last start edge, saturating; only acted on while
    // waiting for count or data bytes.
    timed_out = (to_cnt_q >= TO_LIMIT);
    if (rx_start)       to_cnt_d = 32'd0;
    else if (timed_out) to_cnt_d = to_cnt_q;
    else                to_cnt_d = to_cnt_q + 32'd1;

    case (state_q)
      ST_IDLE: if (byte_valid && hdr_ok(byte_data)) begin
        addr_d  = byte_data[HDR_ADDR_HI:0];
        w_d     = byte_data[HDR_W];
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (byte_err || timed_out) state_d = ST_IDLE;
        else if (byte_valid) begin
          rem_d   = burst_len(byte_data);
          state_d = w_q ? ST_WDATA : ST_RREQ;
        end
      end
      ST_WDATA: begin
        if (byte_err || timed_out) state_d = ST_IDLE;
        else if (byte_valid) begin
          wdata_d = byte_data;
          state_d = ST_WSTROBE;
        end
      end
      ST_WSTROBE: begin
        rem_d = rem_q - 9'd1;
        if (rem_q == 9'd1) begin
          tx_start = 1'b1;
          tx_data  = {w_q, 2'b00, addr_q};
          state_d  = ST_ACK;
        end else begin
          state_d = ST_WDATA;
        end
      end
      ST_RREQ: begin
        rem_d   = rem_q - 9'd1;
        state_d = ST_RWAIT;
      end
      ST_RWAIT: begin
        tx_start = 1'b1;
        tx_data  = csr_readdata;
        state_d  = ST_RSEND;
      end
      ST_RSEND: if (tx_done) state_d = (rem_q == 9'd0) ? ST_IDLE : ST_RREQ;
      ST_ACK:   if (tx_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // TX shifter: start bit goes out immediately, then 8 data bits and
    // the stop bit from tx_sh; done pulses at the end of the stop bit.
    tx_d      = tx_q;
    tx_busy_d = tx_busy_q;
    tx_sh_d   = tx_sh_q;
    tx_cnt_d  = tx_cnt_q;
    tx_bits_d = tx_bits_q;
    if (tx_start) begin
      tx_d      = 1'b0;
      tx_busy_d = 1'b1;
      tx_sh_d   = {1'b1, tx_data};
      tx_cnt_d  = FULL;
      tx_bits_d = 4'd9;
    end else if (tx_busy_q) begin
      if (tx_cnt_q == 16'd0) begin
        if (tx_bits_q == 4'd0) begin
          tx_busy_d = 1'b0;
        end else begin
          tx_d      = tx_sh_q[0];
          tx_sh_d   = {1'b1, tx_sh_q[8:1]};
          tx_bits_d = tx_bits_q - 4'd1;
          tx_cnt_d  = FULL;
        end
      end else begin
        tx_cnt_d = tx_cnt_q - 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= 5'd0;
      w_q       <= 1'b0;
      rem_q     <= 9'd0;
      wdata_q   <= 8'd0;
      to_cnt_q  <= 32'd0;
      tx_q      <= 1'b1;
      tx_busy_q <= 1'b0;
      tx_sh_q   <= 9'h1FF;
      tx_cnt_q  <= 16'd0;
      tx_bits_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      w_q       <= w_d;
      rem_q     <= rem_d;
      wdata_q   <= wdata_d;
      to_cnt_q  <= to_cnt_d;
      tx_q      <= tx_d;
      tx_busy_q <= tx_busy_d;
      tx_sh_q   <= tx_sh_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_bits_q <= tx_bits_d;
    end
  end

  assign tx            = tx_q;
  assign chip_select   = (state_q != ST_IDLE);
  assign csr_read      = (state_q == ST_RREQ);
  assign csr_write     = (state_q == ST_WSTROBE);
  assign csr_address   = addr_q;
  assign csr_writedata = wdata_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_cdbus_uart_bridge.sv
module tb_cdbus_uart_bridge;
  import cdbus_uart_bridge_pkg::*;

  localparam int DIV = 8;
  localparam int TOB = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1;
  logic       tx, chip_select, csr_read, csr_write;
  logic [4:0] csr_address;
  logic [7:0] csr_readdata = 8'h00;
  logic [7:0] csr_writedata;
  logic [3:0] dbg_state;

  cdbus_uart_bridge #(.DIV(DIV), .TIMEOUT_BITS(TOB)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .rx            (rx),
    .tx            (tx),
    .chip_select   (chip_select),
    .csr_address   (csr_address),
    .csr_read      (csr_read),
    .csr_readdata  (csr_readdata),
    .csr_write     (csr_write),
    .csr_writedata (csr_writedata),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  int wr_count = 0;
  int rd_count = 0;
  logic cs_seen = 1'b0;
  logic reset_seen = 1'b0;
  logic [12:0] exp_wr_q[$];   // {address, data}
  logic [4:0]  exp_rd_q[$];   // address
  logic [7:0]  rd_model_q[$]; // CSR read data model
  logic [7:0]  exp_tx_q[$];   // bytes expected on tx

  typedef struct {
    logic       is_write;
    logic [4:0] addr;
    logic [7:0] count;
    logic [7:0] seed;
    logic [7:0] step;
  } frame_t;
  frame_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s: got 0x%0h expected nothing at %0t", name, act, $time);
  endtask

  // ---------------- CSR bus monitor and read data model ----------------
  always @(negedge clk) begin
    if (reset_n) begin
      if (chip_select) cs_seen = 1'b1;
      if (csr_read || csr_write) begin
        check("strobe_cs", 32'(chip_select), 32'd1);
        check("strobe_exclusive", 32'(csr_read & csr_write), 32'd0);
      end
      if (csr_write) begin
        logic [12:0] e;
        wr_count++;
        if (exp_wr_q.size() == 0) fail_now("csr_write_unexpected", 32'({csr_address, csr_writedata}));
        else begin
          e = exp_wr_q.pop_front();
          check("csr_write_addr", 32'(csr_address), 32'(e[12:8]));
          check("csr_write_data", 32'(csr_writedata), 32'(e[7:0]));
        end
      end
      if (csr_read) begin
        rd_count++;
        if (exp_rd_q.size() == 0) fail_now("csr_read_unexpected", 32'(csr_address));
        else check("csr_read_addr", 32'(csr_address), 32'(exp_rd_q.pop_front()));
        csr_readdata = (rd_model_q.size() != 0) ? rd_model_q.pop_front() : 8'hEE;
      end
    end
  end

  // ---------------- TX decoder ----------------
  always @(negedge reset_n) reset_seen = 1'b1;

  logic [7:0] mon_b;
  logic       mon_stop;
  initial begin
    forever begin
      @(negedge tx);
      reset_seen = 1'b0;
      repeat (DIV / 2) @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(posedge clk);
        #1 mon_b[i] = tx;
      end
      repeat (DIV) @(posedge clk);
      #1 mon_stop = tx;
      if (!reset_seen) begin
        if (exp_tx_q.size() == 0) fail_now("tx_unexpected", 32'(mon_b));
        else begin
          check("tx_byte", 32'(mon_b), 32'(exp_tx_q.pop_front()));
          check("tx_stop", 32'(mon_stop), 32'd1);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input logic stop_val);
    rx = 1'b0;
    repeat (DIV) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(posedge clk);
    end
    rx = stop_val;
    repeat (DIV) @(posedge clk);
    rx = 1'b1;
    if (!stop_val) repeat (DIV) @(posedge clk);
  endtask

  task automatic wait_tx_drain(input int budget);
    int c = 0;
    while (exp_tx_q.size() != 0 && c < budget) begin
      @(posedge clk);
      c++;
    end
    check("tx_drain_left", 32'(exp_tx_q.size()), 32'd0);
  endtask

  task automatic wait_cs_low(input int budget);
    int c = 0;
    @(negedge clk);
    while (chip_select && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("cs_low_after_frame", 32'(chip_select), 32'd0);
  endtask

  task automatic run_frame(input frame_t f);
    int n;
    int wr_base, rd_base;
    logic [7:0] hdr, v;
    n = (f.count == 8'd0) ? 256 : int'(f.count);
    hdr = {f.is_write, 2'b00, f.addr};
    wr_base = wr_count;
    rd_base = rd_count;
    for (int i = 0; i < n; i++) begin
      v = f.seed + f.step * 8'(i);
      if (f.is_write) exp_wr_q.push_back({f.addr, v});
      else begin
        rd_model_q.push_back(v);
        exp_rd_q.push_back(f.addr);
        exp_tx_q.push_back(v);
      end
    end
    if (f.is_write) exp_tx_q.push_back(hdr);
    send_byte(hdr, 1'b1);
    send_byte(f.count, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("cs_in_frame", 32'(chip_select), 32'd1);
    if (f.is_write)
      for (int i = 0; i < n; i++) send_byte(f.seed + f.step * 8'(i), 1'b1);
    wait_tx_drain((n + 3) * 10 * DIV * 2);
    wait_cs_low(4 * DIV);
    check("frame_writes", 32'(wr_count - wr_base), f.is_write ? 32'(n) : 32'd0);
    check("frame_reads", 32'(rd_count - rd_base), f.is_write ? 32'd0 : 32'(n));
    check("exp_wr_left", 32'(exp_wr_q.size()), 32'd0);
    check("exp_rd_left", 32'(exp_rd_q.size()), 32'd0);
    repeat (2 * DIV) @(posedge clk);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3_000_000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int base;
    tbl[0] = '{1'b1, 5'd3,  8'd1, 8'h5A, 8'h00};
    tbl[1] = '{1'b0, 5'd6,  8'd3, 8'h11, 8'h11};
    tbl[2] = '{1'b1, 5'd31, 8'd0, 8'h00, 8'h01};
    tbl[3] = '{1'b0, 5'd0,  8'd1, 8'hA5, 8'h00};
    tbl[4] = '{1'b1, 5'd17, 8'd5, 8'hF0, 8'h13};
    tbl[5] = '{1'b0, 5'($urandom_range(0, 31)), 8'($urandom_range(2, 4)),
               8'($urandom_range(0, 255)), 8'h35};

    // reset values
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_cs", 32'(chip_select), 32'd0);
    check("rst_read", 32'(csr_read), 32'd0);
    check("rst_write", 32'(csr_write), 32'd0);
    check("rst_addr", 32'(csr_address), 32'd0);
    check("rst_wdata", 32'(csr_writedata), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    reset_n = 1'b1;
    repeat (10) @(posedge clk);

    for (int i = 0; i < 6; i++) run_frame(tbl[i]);

    // reserved header bits set: dropped silently
    cs_seen = 1'b0;
    send_byte(8'hA3, 1'b1);
    repeat (4 * DIV) @(posedge clk);
    @(negedge clk);
    check("rsv_cs_seen", 32'(cs_seen), 32'd0);
    check("rsv_state", 32'(dbg_state), 32'(ST_IDLE));

    // framing error on a data byte aborts the frame
    base = wr_count;
    send_byte(8'h82, 1'b1);
    send_byte(8'h01, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("ferr_cs_before", 32'(chip_select), 32'd1);
    send_byte(8'h10, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("ferr_cs_after", 32'(chip_select), 32'd0);
    check("ferr_state", 32'(dbg_state), 32'(ST_IDLE));
    check("ferr_no_write", 32'(wr_count - base), 32'd0);
    repeat (12 * DIV) @(posedge clk);

    // timeout after header, then a normal frame
    send_byte(8'h81, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("to_cs_before", 32'(chip_select), 32'd1);
    repeat (TOB * DIV + 1) @(posedge clk);
    @(negedge clk);
    check("to_cs_after", 32'(chip_select), 32'd0);
    check("to_state", 32'(dbg_state), 32'(ST_IDLE));
    run_frame('{1'b1, 5'd1, 8'd1, 8'h44, 8'h00});

    // reset in the middle of the second byte of a 2-byte read
    base = rd_count;
    rd_model_q.push_back(8'hC4);
    rd_model_q.push_back(8'h3B);
    exp_rd_q.push_back(5'd9);
    exp_rd_q.push_back(5'd9);
    exp_tx_q.push_back(8'hC4);
    send_byte(8'h09, 1'b1);
    send_byte(8'h02, 1'b1);
    for (int c = 0; c < 30 * DIV && rd_count < base + 2; c++) @(posedge clk);
    check("rst_mid_reads", 32'(rd_count - base), 32'd2);
    repeat (3 * DIV) @(posedge clk);
    @(negedge clk);
    check("rst_mid_state", 32'(dbg_state), 32'(ST_RSEND));
    reset_n = 1'b0;
    #1;
    check("rst_mid_tx", 32'(tx), 32'd1);
    check("rst_mid_cs", 32'(chip_select), 32'd0);
    check("rst_mid_read", 32'(csr_read), 32'd0);
    check("rst_mid_write", 32'(csr_write), 32'd0);
    repeat (5) @(posedge clk);
    reset_n = 1'b1;
    check("rst_mid_first_byte", 32'(exp_tx_q.size()), 32'd0);
    repeat (12 * DIV) @(posedge clk);
    run_frame('{1'b0, 5'd12, 8'd2, 8'h6D, 8'h21});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
